game_countdown_timer: RTL and testbench

//  Consumer of the 1 Hz one_sec pulse from the slow-clock counter. Holds a BCD M:SS round timer for
//  the game screen, counts it down once per tick while running, supports load/start/pause, and flags
//  low-time warning and expiry. Digits drive the score/timer display; expired drives game control.

---
 rtl/game_countdown_timer_pkg.sv | 20 ++
 rtl/game_countdown_timer_if.sv | 27 ++
 rtl/game_countdown_timer_bcd_down_digit.sv | 38 +++
 rtl/game_countdown_timer.sv | 115 +++++++++++
 tb/tb_game_countdown_timer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/game_countdown_timer_pkg.sv
// Shared types and helpers for the BCD M:SS game round timer.
package game_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

  localparam int BCD_MAX_ONES = 9;
  localparam int BCD_MAX_TENS = 5;

  function automatic logic bcd_is_zero(input logic [3:0] min_d,
                                       input logic [2:0] tens_d,
                                       input logic [3:0] ones_d);
    return (min_d == 4'd0) && (tens_d == 3'd0) && (ones_d == 4'd0);
  endfunction

endpackage

// File: rtl/game_countdown_timer_if.sv
// Control inputs and display/status outputs of the round timer.
interface game_countdown_timer_if;
  logic       one_sec;
  logic       load;
  logic [3:0] preset_min;
  logic [2:0] preset_tens;
  logic [3:0] preset_ones;
  logic       start;
  logic       pause;
  logic [3:0] min_digit;
  logic [2:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       warning;
  logic       expired;
  logic       time_up;

  modport master (
    output one_sec, load, preset_min, preset_tens, preset_ones, start, pause,
    input  min_digit, sec_tens, sec_ones, running, warning, expired, time_up
  );

  modport slave (
    input  one_sec, load, preset_min, preset_tens, preset_ones, start, pause,
    output min_digit, sec_tens, sec_ones, running, warning, expired, time_up
  );
endinterface

// File: rtl/game_countdown_timer_bcd_down_digit.sv
// One BCD down-counting digit; wraps 0->MAX and raises borrow_out to the next digit.
module bcd_down_digit #(
  parameter int MAX       = 9,
  parameter int WIDTH     = 4,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             dec_en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] digit,
  output logic [WIDTH-1:0] digit_next,
  output logic             borrow_out
);

  logic [WIDTH-1:0] digit_reg;

  // digit_next is exported so the parent can judge expiry/warning on the new value
  always_comb begin
    digit_next = digit_reg;
    if (load)
      digit_next = load_val;
    else if (dec_en)
      digit_next = (digit_reg == '0) ? WIDTH'(MAX) : digit_reg - 1'b1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      digit_reg <= WIDTH'(RESET_VAL);
    else
      digit_reg <= digit_next;
  end

  assign borrow_out = dec_en & ~load & (digit_reg == '0);
  assign digit      = digit_reg;

endmodule

// File: rtl/game_countdown_timer.sv
// BCD M:SS countdown driven by the 1 Hz one_sec tick, with load/start/pause control.
module game_countdown_timer
  import game_timer_pkg::*;
#(
  parameter int DEFAULT_MIN = 3,
  parameter int DEFAULT_SEC = 0,
  parameter int MAX_MIN     = 9,
  parameter int WARN_SEC    = 10
) (
  input  logic                   clk,
  input  logic                   resetN,
  game_countdown_timer_if.slave  tif
);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_RUNNING = RUNNING;
  localparam logic [1:0] ST_PAUSED  = PAUSED;
  localparam logic [1:0] ST_EXPIRED = EXPIRED;

  logic [1:0] state_reg, state_next;
  logic       tick_d_reg;
  logic       tick_rise;
  logic       dec_en;
  logic       expired_next, warning_next;
  logic       running_reg, warning_reg, expired_reg, time_up_reg;

  logic [3:0] load_min, load_ones;
  logic [2:0] load_tens;
  logic [3:0] min_cur, min_next, ones_cur, ones_next;
  logic [2:0] tens_cur, tens_next;
  logic       ones_borrow, tens_borrow, min_borrow;
  logic [6:0] next_secs;

  assign tick_rise = tif.one_sec & ~tick_d_reg;

  // A tick is dropped whenever a higher-priority control is present this cycle
  assign dec_en = (state_reg == ST_RUNNING) & tick_rise & ~tif.load & ~tif.pause;

  always_comb begin
    load_min  = (tif.preset_min  > 4'(MAX_MIN))      ? 4'(MAX_MIN)      : tif.preset_min;
    load_tens = (tif.preset_tens > 3'(BCD_MAX_TENS)) ? 3'(BCD_MAX_TENS) : tif.preset_tens;
    load_ones = (tif.preset_ones > 4'(BCD_MAX_ONES)) ? 4'(BCD_MAX_ONES) : tif.preset_ones;
  end

  bcd_down_digit #(.MAX(BCD_MAX_ONES), .WIDTH(4), .RESET_VAL(DEFAULT_SEC % 10)) u_ones (
    .clk(clk), .resetN(resetN), .dec_en(dec_en), .load(tif.load), .load_val(load_ones),
    .digit(ones_cur), .digit_next(ones_next), .borrow_out(ones_borrow)
  );

  bcd_down_digit #(.MAX(BCD_MAX_TENS), .WIDTH(3), .RESET_VAL(DEFAULT_SEC / 10)) u_tens (
    .clk(clk), .resetN(resetN), .dec_en(ones_borrow), .load(tif.load), .load_val(load_tens),
    .digit(tens_cur), .digit_next(tens_next), .borrow_out(tens_borrow)
  );

  // Minutes never wrap in practice: RUNNING is never entered at 0:00
  bcd_down_digit #(.MAX(MAX_MIN), .WIDTH(4), .RESET_VAL(DEFAULT_MIN)) u_min (
    .clk(clk), .resetN(resetN), .dec_en(tens_borrow), .load(tif.load), .load_val(load_min),
    .digit(min_cur), .digit_next(min_next), .borrow_out(min_borrow)
  );

  always_comb begin
    state_next   = state_reg;
    expired_next = 1'b0;
    if (tif.load) begin
      state_next = ST_IDLE;
    end else if (tif.start && (state_reg == ST_IDLE || state_reg == ST_PAUSED)) begin
      if (bcd_is_zero(min_cur, tens_cur, ones_cur)) begin
        state_next   = ST_EXPIRED;
        expired_next = 1'b1;
      end else begin
        state_next = ST_RUNNING;
      end
    end else if (tif.pause && state_reg == ST_RUNNING) begin
      state_next = ST_PAUSED;
    end else if (dec_en && bcd_is_zero(min_next, tens_next, ones_next)) begin
      state_next   = ST_EXPIRED;
      expired_next = 1'b1;
    end
  end

  assign next_secs = {4'b0000, tens_next} * 7'd10 + {3'b000, ones_next};

  always_comb begin
    warning_next = (state_next == ST_RUNNING || state_next == ST_PAUSED) &&
                   (min_next == 4'd0) && (next_secs != 7'd0) &&
                   (next_secs <= 7'(WARN_SEC));
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg   <= ST_IDLE;
      tick_d_reg  <= 1'b0;
      running_reg <= 1'b0;
      warning_reg <= 1'b0;
      expired_reg <= 1'b0;
      time_up_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tick_d_reg  <= tif.one_sec;
      running_reg <= (state_next == ST_RUNNING);
      warning_reg <= warning_next;
      expired_reg <= expired_next;
      time_up_reg <= (state_next == ST_EXPIRED);
    end
  end

  assign tif.min_digit = min_cur;
  assign tif.sec_tens  = tens_cur;
  assign tif.sec_ones  = ones_cur;
  assign tif.running   = running_reg;
  assign tif.warning   = warning_reg;
  assign tif.expired   = expired_reg;
  assign tif.time_up   = time_up_reg;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed plus random stimulus against a seconds-count reference model of the round timer.
module tb_game_countdown_timer;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  int   total = 0;
  int   bad = 0;

  game_countdown_timer_if tif();

  game_countdown_timer #(
    .DEFAULT_MIN(3), .DEFAULT_SEC(0), .MAX_MIN(9), .WARN_SEC(10)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .tif(tif.slave)
  );

  always #5 clk = ~clk;

  // Reference model: remaining time as plain seconds, mode 0=idle 1=run 2=paused 3=expired
  int m_secs;
  int m_mode;
  bit m_prev;
  bit m_pulse;
  int n_pulses;

  function automatic int clampi(input int v, input int hi);
    return (v > hi) ? hi : v;
  endfunction

  task automatic model_reset();
    m_secs  = 180;
    m_mode  = 0;
    m_prev  = 1'b0;
    m_pulse = 1'b0;
  endtask

  task automatic model_step();
    bit rise;
    rise    = tif.one_sec && !m_prev;
    m_prev  = tif.one_sec;
    m_pulse = 1'b0;
    if (tif.load) begin
      m_secs = clampi(int'(tif.preset_min), 9) * 60 + clampi(int'(tif.preset_tens), 5) * 10 +
               clampi(int'(tif.preset_ones), 9);
      m_mode = 0;
    end else if (tif.start && (m_mode == 0 || m_mode == 2)) begin
      if (m_secs == 0) begin
        m_mode  = 3;
        m_pulse = 1'b1;
      end else begin
        m_mode = 1;
      end
    end else if (tif.pause && m_mode == 1) begin
      m_mode = 2;
    end else if (m_mode == 1 && rise) begin
      m_secs = m_secs - 1;
      if (m_secs == 0) begin
        m_mode  = 3;
        m_pulse = 1'b1;
      end
    end
    if (m_pulse) n_pulses++;
  endtask

  task automatic check(input string tag, input int obs, input int exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int warn;
    warn = ((m_mode == 1 || m_mode == 2) && m_secs > 0 && m_secs <= 10) ? 1 : 0;
    check({tag, ".min"},  int'(tif.min_digit), m_secs / 60);
    check({tag, ".tens"}, int'(tif.sec_tens), (m_secs % 60) / 10);
    check({tag, ".ones"}, int'(tif.sec_ones), m_secs % 10);
    check({tag, ".run"},  int'(tif.running), (m_mode == 1) ? 1 : 0);
    check({tag, ".warn"}, int'(tif.warning), warn);
    check({tag, ".exp"},  int'(tif.expired), int'(m_pulse));
    check({tag, ".tup"},  int'(tif.time_up), (m_mode == 3) ? 1 : 0);
    $display("%s t=%0t %0d:%0d%0d run=%0b warn=%0b exp=%0b tup=%0b", tag, $time,
             tif.min_digit, tif.sec_tens, tif.sec_ones, tif.running, tif.warning,
             tif.expired, tif.time_up);
  endtask

  task automatic step(input string tag, input bit ld, input bit st, input bit ps, input bit os);
    tif.load    = ld;
    tif.start   = st;
    tif.pause   = ps;
    tif.one_sec = os;
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_preset(input int mn, input int tn, input int on);
    tif.preset_min  = 4'(mn);
    tif.preset_tens = 3'(tn);
    tif.preset_ones = 4'(on);
  endtask

  // One second: a single-cycle tick followed by idle cycles
  task automatic one_tick(input string tag);
    step(tag, 0, 0, 0, 1);
    step(tag, 0, 0, 0, 0);
    step(tag, 0, 0, 0, 0);
  endtask

  initial begin
    int pulses_before;
    tif.load = 0; tif.start = 0; tif.pause = 0; tif.one_sec = 0;
    set_preset(0, 0, 0);
    model_reset();
    n_pulses = 0;

    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    resetN = 1'b1;

    // 0:12 down to expiry
    set_preset(0, 1, 2);
    step("ld012", 1, 0, 0, 0);
    step("start", 0, 1, 0, 0);
    pulses_before = n_pulses;
    for (int i = 0; i < 12; i++) one_tick("cnt12");
    check("exp_pulses", n_pulses - pulses_before, 1);
    step("expired_hold", 0, 0, 0, 0);
    one_tick("exp_tick");

    // 1:00 -> 0:59 full borrow
    set_preset(1, 0, 0);
    step("ld100", 1, 0, 0, 0);
    step("start", 0, 1, 0, 0);
    one_tick("borrow");

    // pause/resume at 2:30
    set_preset(2, 3, 0);
    step("ld230", 1, 0, 0, 0);
    step("start", 0, 1, 0, 0);
    step("pause", 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) one_tick("paused");
    step("resume", 0, 1, 0, 0);
    one_tick("run229");
    step("pause_tick", 0, 0, 1, 1);
    step("pause_tick2", 0, 0, 0, 0);
    step("resume2", 0, 1, 0, 0);

    // one_sec held high counts once
    for (int i = 0; i < 20; i++) step("held", 0, 0, 0, 1);
    step("held_end", 0, 0, 0, 0);

    // clamp and start on 0:00
    set_preset(12, 7, 15);
    step("clamp", 1, 0, 0, 0);
    set_preset(0, 0, 0);
    step("ld000", 1, 0, 0, 0);
    step("start0", 0, 1, 0, 0);
    step("after0", 0, 0, 0, 0);

    // load with tick in EXPIRED
    set_preset(0, 4, 5);
    step("ld_tick", 1, 0, 0, 1);
    step("idle_tick", 0, 0, 0, 0);
    one_tick("idle_tick");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bit ld, st, ps, os;
      ld = ($urandom_range(0, 39) == 0);
      st = ($urandom_range(0, 9) == 0);
      ps = ($urandom_range(0, 19) == 0);
      os = ($urandom_range(0, 2) == 0);
      if (ld) set_preset($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 15));
      if (ld && $urandom_range(0, 1) == 0) set_preset(0, 0, $urandom_range(0, 9));
      step("rand", ld, st, ps, os);
    end

    // asynchronous reset mid-count
    set_preset(1, 2, 3);
    step("ld123", 1, 0, 0, 0);
    step("start", 0, 1, 0, 0);
    one_tick("pre_rst");
    #3;
    resetN = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    resetN = 1'b1;
    step("post_rst", 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
